// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates and sequences accesses to the single unified memory of the
// multicycle CPU. It has two requesters:
//   C - the CPU side (merged fetch/data path after address selection)
//   D - a secondary master (program loader, debug or DMA engine)
// One request is accepted at a time. The memory is driven for a fixed window
// of LAT cycles. The winner then gets a one-cycle ack and, for reads, a
// registered read word.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   c_req_i/c_wr_i/c_addr_i/c_wdata_i   CPU request (req held until ack)
//   c_gnt_o, c_ack_o, c_rdata_o    CPU accept pulse, done pulse, read data
//   d_*                            secondary master, same meaning as c_*
//   m_en_o/m_wr_o/m_addr_o/m_wdata_o    memory access controls
//   m_rdata_i                      memory read data, valid in last ACCESS cycle
//   busy_o                         arbiter not idle
//
// Configuration macro
//   MEM_ARB_FIXED_PRI_EN  when defined, C always wins a tie and D can starve.
//                         When undefined, ties are resolved round-robin.
//
// Every output comes from a register or from registered state only.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW  = 10,
   parameter int LAT = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          c_req_i,
   input  logic          c_wr_i,
   input  logic [AW-1:0] c_addr_i,
   input  logic [31:0]   c_wdata_i,
   output logic          c_gnt_o,
   output logic          c_ack_o,
   output logic [31:0]   c_rdata_o,
   input  logic          d_req_i,
   input  logic          d_wr_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [31:0]   d_wdata_i,
   output logic          d_gnt_o,
   output logic          d_ack_o,
   output logic [31:0]   d_rdata_o,
   output logic          m_en_o,
   output logic          m_wr_o,
   output logic [AW-1:0] m_addr_o,
   output logic [31:0]   m_wdata_o,
   input  logic [31:0]   m_rdata_i,
   output logic          busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic       OWN_C    = 1'b0;
   localparam logic       OWN_D    = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

`ifdef MEM_ARB_FIXED_PRI_EN
   localparam bit FIXED_PRI = 1'b1;
`else
   localparam bit FIXED_PRI = 1'b0;
`endif

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          owner_q;
   logic          last_owner_q;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   c_rdata_q;
   logic [31:0]   d_rdata_q;
   logic          c_gnt_q;
   logic          d_gnt_q;
   logic          c_ack_q;
   logic          d_ack_q;
   logic          m_en_q;
   logic          d_wins;

   // D wins when it is the only requester. On a tie it wins only when C
   // owned the previous transaction, unless fixed priority is configured.
   always_comb begin
      d_wins = d_req_i & (~c_req_i | (~FIXED_PRI & (last_owner_q == OWN_C)));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= OWN_C;
         last_owner_q <= OWN_D;   // so that C wins the first tie
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         c_rdata_q    <= 32'd0;
         d_rdata_q    <= 32'd0;
         c_gnt_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         c_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         m_en_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               c_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               if (c_req_i || d_req_i) begin
                  owner_q <= d_wins;
                  wr_q    <= d_wins ? d_wr_i    : c_wr_i;
                  addr_q  <= d_wins ? d_addr_i  : c_addr_i;
                  wdata_q <= d_wins ? d_wdata_i : c_wdata_i;
                  cnt_q   <= CNT_INIT;
                  c_gnt_q <= ~d_wins;
                  d_gnt_q <= d_wins;
                  m_en_q  <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               // The grant pulse covers only the first ACCESS cycle.
               c_gnt_q <= 1'b0;
               d_gnt_q <= 1'b0;
               if (cnt_q == 4'd0) begin
                  // A write leaves the owner's read register unchanged.
                  if (!wr_q) begin
                     if (owner_q == OWN_C) c_rdata_q <= m_rdata_i;
                     else                  d_rdata_q <= m_rdata_i;
                  end
                  m_en_q  <= 1'b0;
                  c_ack_q <= (owner_q == OWN_C);
                  d_ack_q <= (owner_q == OWN_D);
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               c_ack_q      <= 1'b0;
               d_ack_q      <= 1'b0;
               last_owner_q <= owner_q;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign c_gnt_o   = c_gnt_q;
   assign d_gnt_o   = d_gnt_q;
   assign c_ack_o   = c_ack_q;
   assign d_ack_o   = d_ack_q;
   assign c_rdata_o = c_rdata_q;
   assign d_rdata_o = d_rdata_q;
   assign m_en_o    = m_en_q;
   assign m_wr_o    = m_en_q & wr_q;
   assign m_addr_o  = addr_q;
   assign m_wdata_o = wdata_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. It uses two instances that share the
// same inputs: dut_a with LAT=1 and dut_b with LAT=3. Each instance has its
// own memory model. Expected responses are pushed to a scoreboard queue when
// a request is driven. They are popped and compared when an ack appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int AW = 10;

`ifdef MEM_ARB_FIXED_PRI_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          c_req, c_wr, d_req, d_wr;
   logic [AW-1:0] c_addr, d_addr;
   logic [31:0]   c_wdata, d_wdata;

   logic          a_c_gnt, a_c_ack, a_d_gnt, a_d_ack, a_m_en, a_m_wr, a_busy;
   logic [31:0]   a_c_rdata, a_d_rdata, a_m_wdata, a_m_rdata;
   logic [AW-1:0] a_m_addr;
   logic          b_c_gnt, b_c_ack, b_d_gnt, b_d_ack, b_m_en, b_m_wr, b_busy;
   logic [31:0]   b_c_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
   logic [AW-1:0] b_m_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .LAT(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .c_req_i(c_req), .c_wr_i(c_wr), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
      .c_gnt_o(a_c_gnt), .c_ack_o(a_c_ack), .c_rdata_o(a_c_rdata),
      .d_req_i(d_req), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(a_d_gnt), .d_ack_o(a_d_ack), .d_rdata_o(a_d_rdata),
      .m_en_o(a_m_en), .m_wr_o(a_m_wr), .m_addr_o(a_m_addr), .m_wdata_o(a_m_wdata),
      .m_rdata_i(a_m_rdata), .busy_o(a_busy)
   );

   mem_arbiter #(.AW(AW), .LAT(3)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .c_req_i(c_req), .c_wr_i(c_wr), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
      .c_gnt_o(b_c_gnt), .c_ack_o(b_c_ack), .c_rdata_o(b_c_rdata),
      .d_req_i(d_req), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(b_d_gnt), .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata),
      .m_en_o(b_m_en), .m_wr_o(b_m_wr), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata),
      .m_rdata_i(b_m_rdata), .busy_o(b_busy)
   );

   // Memory models: unwritten words return a fixed address-derived pattern.
   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];
   bit          wr_a  [1024];
   bit          wr_b  [1024];

   function automatic logic [31:0] pat(input logic [AW-1:0] a);
      return (a == 10'h004) ? 32'h1234ABCD : {16'hC0DE, 6'b0, a};
   endfunction

   always @(posedge clk) begin
      if (a_m_en && a_m_wr) begin
         mem_a[a_m_addr] <= a_m_wdata;
         wr_a[a_m_addr]  <= 1'b1;
      end
      if (b_m_en && b_m_wr) begin
         mem_b[b_m_addr] <= b_m_wdata;
         wr_b[b_m_addr]  <= 1'b1;
      end
   end

   assign a_m_rdata = wr_a[a_m_addr] ? mem_a[a_m_addr] : pat(a_m_addr);
   assign b_m_rdata = wr_b[b_m_addr] ? mem_b[b_m_addr] : pat(b_m_addr);

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        port;   // 0 = C, 1 = D
      logic [31:0] rdata;
      string       tag;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   exp_rdata;   // used for reads only
      string         tag;
   } vec_t;
   vec_t tbl[8];

   logic [31:0] last_c, last_d;   // expected rdata registers of dut_b

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample one cycle of dut_b: check exclusivity and score any ack.
   task automatic watch_b(output bit acked);
      exp_t e;
      acked = b_c_ack | b_d_ack;
      if (b_c_gnt | b_d_gnt) chk("gnt_excl", 32'(b_c_gnt & b_d_gnt), 32'd0);
      if (acked) begin
         chk("ack_excl", 32'(b_c_ack & b_d_ack), 32'd0);
         chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_ack_port"}, 32'(b_d_ack), 32'(e.port));
            chk({e.tag, "_rdata"}, e.port ? b_d_rdata : b_c_rdata, e.rdata);
            $display("txn %s port=%s c_rdata=%h d_rdata=%h", e.tag,
                     b_d_ack ? "D" : "C", b_c_rdata, b_d_rdata);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      c_req = 0; d_req = 0; c_wr = 0; d_wr = 0;
      c_addr = '0; d_addr = '0; c_wdata = 0; d_wdata = 0;
      #1;
      chk("rst_b_ctrl", 32'({b_c_gnt, b_d_gnt, b_c_ack, b_d_ack, b_m_en, b_m_wr, b_busy}), 32'd0);
      chk("rst_b_data", b_c_rdata | b_d_rdata | b_m_wdata | 32'(b_m_addr), 32'd0);
      chk("rst_a_ctrl", 32'({a_c_gnt, a_d_gnt, a_c_ack, a_d_ack, a_m_en, a_m_wr, a_busy}), 32'd0);
      tick();
      rst_n  = 1'b1;
      last_c = 32'd0;
      last_d = 32'd0;
      sbq.delete();
   endtask

   // One single-requester transaction on dut_b (LAT=3).
   task automatic do_txn_b(input vec_t v);
      logic [31:0] exp_rd;
      int          en_cnt, ack_cyc;
      bit          acked;
      if (v.wr) exp_rd = v.port ? last_d : last_c;
      else begin
         exp_rd = v.exp_rdata;
         if (v.port) last_d = exp_rd; else last_c = exp_rd;
      end
      sbq.push_back('{v.port, exp_rd, v.tag});
      c_req = ~v.port; c_wr = v.wr; c_addr = v.addr; c_wdata = v.wdata;
      d_req =  v.port; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
      tick();
      chk({v.tag, "_gnt"}, 32'(v.port ? b_d_gnt : b_c_gnt), 32'd1);
      en_cnt  = 0;
      ack_cyc = 0;
      for (int cyc = 1; cyc < 40; cyc++) begin
         if (b_m_en) begin
            en_cnt++;
            chk({v.tag, "_m_addr"}, 32'(b_m_addr), 32'(v.addr));
            chk({v.tag, "_m_wr"}, 32'(b_m_wr), 32'(v.wr));
            if (v.wr) chk({v.tag, "_m_wdata"}, b_m_wdata, v.wdata);
         end
         watch_b(acked);
         if (acked) begin
            ack_cyc = cyc;
            break;
         end
         tick();
      end
      c_req = 0; d_req = 0;
      chk({v.tag, "_en_cycles"}, 32'(en_cnt), 32'd3);
      chk({v.tag, "_ack_cycle"}, 32'(ack_cyc), 32'd4);
      tick();
      chk({v.tag, "_idle"}, 32'(b_busy), 32'd0);
   endtask

   initial begin
      bit acked;
      int acks, gnts, dg, en_seen;
      logic exp_p;

      tbl[0] = '{1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, 32'h0,        "d_wr_3ff"};
      tbl[1] = '{1'b0, 1'b0, 10'h3FF, 32'h0,        32'hDEADBEEF, "c_rd_3ff"};
      tbl[2] = '{1'b0, 1'b1, 10'h010, 32'h0BADF00D, 32'h0,        "c_wr_010"};
      tbl[3] = '{1'b1, 1'b0, 10'h010, 32'h0,        32'h0BADF00D, "d_rd_010"};
      tbl[4] = '{1'b0, 1'b0, 10'h004, 32'h0,        32'h1234ABCD, "c_rd_004"};
      tbl[5] = '{1'b1, 1'b0, 10'h123, 32'h0,        32'hC0DE0123, "d_rd_123"};
      tbl[6] = '{1'b1, 1'b1, 10'h004, 32'h55AA55AA, 32'h0,        "d_wr_004"};
      tbl[7] = '{1'b0, 1'b0, 10'h004, 32'h0,        32'h55AA55AA, "c_rd_004b"};

      // LAT=1 read on dut_a: gnt/m_en in cycle 1, ack in 2, idle in 3.
      do_reset();
      c_req = 1; c_wr = 0; c_addr = 10'h004;
      tick();
      chk("lat1_gnt", 32'(a_c_gnt), 32'd1);
      chk("lat1_m_en", 32'(a_m_en), 32'd1);
      chk("lat1_m_addr", 32'(a_m_addr), 32'h004);
      tick();
      chk("lat1_ack", 32'(a_c_ack), 32'd1);
      chk("lat1_rdata", a_c_rdata, 32'h1234ABCD);
      $display("txn lat1_c_rd_004 port=C rdata=%h", a_c_rdata);
      c_req = 0;
      tick();
      chk("lat1_busy", 32'(a_busy), 32'd0);

      // Table-driven single transactions on dut_b.
      do_reset();
      for (int i = 0; i < 8; i++) do_txn_b(tbl[i]);

      // Both ports request together and hold: alternate, or C only if fixed.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         exp_p = FIXED ? 1'b0 : k[0];
         sbq.push_back('{exp_p, exp_p ? 32'h0BADF00D : 32'hDEADBEEF, "both"});
      end
      c_req = 1; c_wr = 0; c_addr = 10'h3FF;
      d_req = 1; d_wr = 0; d_addr = 10'h010;
      acks = 0; gnts = 0; dg = 0;
      for (int cyc = 0; cyc < 60 && acks < 6; cyc++) begin
         tick();
         if (b_c_gnt | b_d_gnt) begin
            exp_p = FIXED ? 1'b0 : gnts[0];
            chk("both_gnt_port", 32'(b_d_gnt), 32'(exp_p));
            gnts++;
         end
         if (b_d_gnt) dg++;
         watch_b(acked);
         if (acked) acks++;
      end
      c_req = 0; d_req = 0;
      chk("both_ack_count", 32'(acks), 32'd6);
      chk("both_sb_empty", 32'(sbq.size()), 32'd0);
      chk("both_d_gnt_count", 32'(dg), FIXED ? 32'd0 : 32'd3);
      tick();
      tick();

      // Request withdrawn and inputs changed after the grant.
      sbq.push_back('{1'b0, 32'h0BADF00D, "withdraw"});
      c_req = 1; c_wr = 0; c_addr = 10'h010;
      tick();
      chk("withdraw_gnt", 32'(b_c_gnt), 32'd1);
      c_req = 0; c_addr = 10'h155; c_wr = 1; c_wdata = 32'hFFFFFFFF;
      acked = 0; en_seen = 0;
      for (int cyc = 0; cyc < 20 && !acked; cyc++) begin
         if (b_m_en) begin
            en_seen++;
            chk("withdraw_m_addr", 32'(b_m_addr), 32'h010);
            chk("withdraw_m_wr", 32'(b_m_wr), 32'd0);
         end
         watch_b(acked);
         if (!acked) tick();
      end
      chk("withdraw_acked", 32'(acked), 32'd1);
      chk("withdraw_en_cycles", 32'(en_seen), 32'd3);
      c_wr = 0;
      tick();

      // Reset asserted in the second ACCESS cycle, then a fresh grant.
      c_req = 1; c_wr = 0; c_addr = 10'h3FF;
      tick();
      tick();
      chk("abort_in_access", 32'(b_m_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", 32'({b_c_gnt, b_d_gnt, b_c_ack, b_d_ack, b_m_en, b_m_wr, b_busy}), 32'd0);
      chk("abort_rdata", b_c_rdata | b_d_rdata, 32'd0);
      tick();
      chk("abort_no_ack", 32'(b_c_ack | b_d_ack), 32'd0);
      rst_n = 1'b1;
      sbq.delete();
      tick();
      chk("abort_regnt", 32'(b_c_gnt), 32'd1);
      sbq.push_back('{1'b0, 32'hDEADBEEF, "after_abort"});
      acked = 0;
      for (int cyc = 0; cyc < 20 && !acked; cyc++) begin
         watch_b(acked);
         if (!acked) tick();
      end
      chk("after_abort_acked", 32'(acked), 32'd1);
      c_req = 0;
      tick();
      tick();

      // Idle: nothing moves for 20 cycles.
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         chk("idle_b", 32'({b_c_gnt, b_d_gnt, b_c_ack, b_d_ack, b_m_en, b_busy}), 32'd0);
         chk("idle_a", 32'({a_c_gnt, a_d_gnt, a_c_ack, a_d_ack, a_m_en, a_busy}), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
